// File: rtl/fft_frame_reader_if.sv
// Output stream of the FFT frame reader: complex word plus frame markers on valid/ready.
interface fft_frame_reader_if #(
  parameter int DRAMWIDTH = 32
);
  logic [DRAMWIDTH/2-1:0] re_data;
  logic [DRAMWIDTH/2-1:0] im_data;
  logic                   data_valid;
  logic                   data_ready;
  logic                   data_sof;
  logic                   data_eof;

  modport master (output re_data, im_data, data_valid, data_sof, data_eof, input data_ready);
  modport slave  (input re_data, im_data, data_valid, data_sof, data_eof, output data_ready);
endinterface

// File: rtl/fft_frame_reader.sv
// Streams one complex FFT frame from a sample RAM onto a valid/ready stream with sof/eof.
// Optional bit-reversed read order is built when FFT_RD_BITREV_EN is defined.
module fft_frame_reader #(
  parameter int DRAMWIDTH = 32,
  parameter int ARAMWIDTH = 7,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 en_in,
  input  logic [4:0]           frame_log2_in,
`ifdef FFT_RD_BITREV_EN
  input  logic                 bitrev_in,
`endif
  output logic [ARAMWIDTH-1:0] ram_addr,
  output logic                 read_en,
  input  logic [DRAMWIDTH-1:0] ram_data,
  output logic                 busy,
  output logic                 done,
  fft_frame_reader_if.master   out
);
  localparam int DEPTH = RD_LAT + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int OW    = $clog2(RD_LAT + DEPTH + 1);
  localparam int IW    = (ARAMWIDTH > 1) ? $clog2(ARAMWIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                 state, state_n;
  logic [4:0]             l_q, l_in;
  logic [ARAMWIDTH-1:0]   idx, last_idx, addr_f;
  logic [ARAMWIDTH:0]     span;
  logic [RD_LAT:1]        vld_pipe;
  logic [RD_LAT:1][1:0]   tag_pipe;
  logic [DEPTH-1:0][DRAMWIDTH+1:0] fifo;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          cnt;
  logic [OW-1:0]          pipe_cnt, occ;
  logic                   credit, wr, rd, valid;
  logic [DRAMWIDTH+1:0]   head;
`ifdef FFT_RD_BITREV_EN
  logic                   br_q;
`endif

  always_comb begin
    if (frame_log2_in == 5'd0)                 l_in = 5'd1;
    else if (frame_log2_in > 5'(ARAMWIDTH))    l_in = 5'(ARAMWIDTH);
    else                                       l_in = frame_log2_in;
  end

  assign span     = (ARAMWIDTH+1)'(1) << l_q;
  assign last_idx = ARAMWIDTH'(span - 1'b1);

  always_comb begin
    addr_f = idx;
`ifdef FFT_RD_BITREV_EN
    // reverse only the low L bits; upper address bits stay zero
    if (br_q) begin
      addr_f = '0;
      for (int i = 0; i < ARAMWIDTH; i++)
        if (i < int'(l_q)) addr_f[i] = idx[IW'(int'(l_q) - 1 - i)];
    end
`endif
  end

  // credit counts words in flight plus words buffered, before this cycle's pop
  always_comb begin
    pipe_cnt = '0;
    for (int k = 1; k <= RD_LAT; k++) pipe_cnt = pipe_cnt + OW'(vld_pipe[k]);
  end
  assign occ    = pipe_cnt + OW'(cnt);
  assign credit = occ < OW'(DEPTH);

  assign read_en  = (state == ISSUE) && credit;
  assign ram_addr = (state == ISSUE) ? addr_f : '0;
  assign busy     = (state != IDLE);

  always_comb begin
    state_n = state;
    done    = 1'b0;
    case (state)
      IDLE:  if (en_in) state_n = ISSUE;
      ISSUE: if (read_en && idx == last_idx) state_n = DRAIN;
      DRAIN: if (pipe_cnt == '0 && cnt == '0) begin
               done    = 1'b1;
               state_n = IDLE;
             end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      l_q   <= 5'd1;
      idx   <= '0;
`ifdef FFT_RD_BITREV_EN
      br_q  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && en_in) begin
        l_q <= l_in;
        idx <= '0;
`ifdef FFT_RD_BITREV_EN
        br_q <= bitrev_in;
`endif
      end else if (read_en) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // valid + {eof,sof} ride alongside the RAM latency
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[1] <= read_en;
      tag_pipe[1] <= {idx == last_idx, idx == '0};
      for (int k = 2; k <= RD_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  assign valid = (cnt != '0);
  assign wr    = vld_pipe[RD_LAT];
  assign rd    = valid && out.data_ready;
  assign head  = fifo[rd_ptr];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fifo   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr) begin
        fifo[wr_ptr] <= {tag_pipe[RD_LAT], ram_data};
        wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (rd) rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      cnt <= cnt + CW'(wr) - CW'(rd);
    end
  end

  assign out.data_valid = valid;
  assign out.re_data    = valid ? head[DRAMWIDTH/2-1:0]         : '0;
  assign out.im_data    = valid ? head[DRAMWIDTH-1:DRAMWIDTH/2] : '0;
  assign out.data_sof   = valid & head[DRAMWIDTH];
  assign out.data_eof   = valid & head[DRAMWIDTH+1];
endmodule

// File: tb/tb_fft_frame_reader.sv
// Bench: two readers (RD_LAT=1 and RD_LAT=3) share stimulus; a frame-level model checks both.
module tb_fft_frame_reader;
  localparam int AW = 7;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic ready = 1'b1;
  logic [4:0] flog2 = 5'd0;
`ifdef FFT_RD_BITREV_EN
  logic bitrev = 1'b0;
`endif
  always #5 clk = ~clk;

  fft_frame_reader_if #(.DRAMWIDTH(DW)) s0 ();
  fft_frame_reader_if #(.DRAMWIDTH(DW)) s1 ();
  assign s0.data_ready = ready;
  assign s1.data_ready = ready;

  logic [AW-1:0] addr0, addr1;
  logic re0, re1, busy0, busy1, done0, done1;
  logic [DW-1:0] rd0, rd1;
  logic [DW-1:0] mem [128];
  logic [DW-1:0] p1 [3];

  fft_frame_reader #(.DRAMWIDTH(DW), .ARAMWIDTH(AW), .RD_LAT(1)) u0 (
    .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .frame_log2_in(flog2),
`ifdef FFT_RD_BITREV_EN
    .bitrev_in(bitrev),
`endif
    .ram_addr(addr0), .read_en(re0), .ram_data(rd0),
    .busy(busy0), .done(done0), .out(s0.master));

  fft_frame_reader #(.DRAMWIDTH(DW), .ARAMWIDTH(AW), .RD_LAT(3)) u1 (
    .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .frame_log2_in(flog2),
`ifdef FFT_RD_BITREV_EN
    .bitrev_in(bitrev),
`endif
    .ram_addr(addr1), .read_en(re1), .ram_data(rd1),
    .busy(busy1), .done(done1), .out(s1.master));

  // RAM models with 1- and 3-cycle read latency
  always @(posedge clk) rd0 <= mem[addr0];
  always @(posedge clk) begin
    p1[0] <= mem[addr1];
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign rd1 = p1[2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_addr [128];
  int exp_n = 0;
  int ra [2], wd [2], first_rd [2], first_vld [2], sof_c [2], eof_c [2], done_c [2];
  logic stall [2];
  logic [DW-1:0] prev_w [2];
  logic [1:0] prev_t [2];
  logic armed = 1'b0;
  logic mon_en = 1'b0;
  int c0 = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int brev(int k, int l);
    int r = 0;
    for (int b = 0; b < l; b++) r = r * 2 + ((k >> b) & 1);
    return r;
  endfunction

  task automatic mon(int d, logic r_en, logic [AW-1:0] a, logic v, logic [DW/2-1:0] re,
                     logic [DW/2-1:0] im, logic sof, logic eof, logic dn);
    int cap = (d == 0) ? 3 : 5;
    logic exp_re;
    exp_re = armed && (ra[d] < exp_n) && ((ra[d] - wd[d]) < cap);
    chk($sformatf("read_en%0d@%0d", d, cyc), 32'(r_en), 32'(exp_re));
    if (r_en) begin
      if (ra[d] < exp_n) chk($sformatf("addr%0d[%0d]", d, ra[d]), 32'(a), exp_addr[ra[d]]);
      if (first_rd[d] < 0) first_rd[d] = cyc;
      ra[d]++;
    end
    if (stall[d]) begin
      chk($sformatf("stall_valid%0d", d), 32'(v), 32'd1);
      chk($sformatf("stall_word%0d", d), {im, re}, prev_w[d]);
      chk($sformatf("stall_tag%0d", d), 32'({eof, sof}), 32'(prev_t[d]));
    end
    if (v && first_vld[d] < 0) first_vld[d] = cyc;
    if (v && ready) begin
      if (wd[d] < exp_n) begin
        chk($sformatf("word%0d[%0d]", d, wd[d]), {im, re}, mem[7'(exp_addr[wd[d]])]);
        chk($sformatf("sof%0d[%0d]", d, wd[d]), 32'(sof), 32'(wd[d] == 0));
        chk($sformatf("eof%0d[%0d]", d, wd[d]), 32'(eof), 32'(wd[d] == exp_n - 1));
      end else begin
        chk($sformatf("extra_word%0d", d), 32'd1, 32'd0);
      end
      if (sof) sof_c[d] = cyc;
      if (eof) eof_c[d] = cyc;
      wd[d]++;
    end
    stall[d]  = v && !ready;
    prev_w[d] = {im, re};
    prev_t[d] = {eof, sof};
    if (dn) begin
      chk($sformatf("done_count%0d", d), 32'(wd[d]), 32'(exp_n));
      chk($sformatf("single_done%0d", d), 32'(done_c[d] < 0), 32'd1);
      done_c[d] = cyc;
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    mon(0, re0, addr0, s0.data_valid, s0.re_data, s0.im_data, s0.data_sof, s0.data_eof, done0);
    mon(1, re1, addr1, s1.data_valid, s1.re_data, s1.im_data, s1.data_sof, s1.data_eof, done1);
  end

  task automatic chk_quiet(string tag);
    chk({tag, "_re0"}, 32'({re0, addr0, busy0, done0}), 32'd0);
    chk({tag, "_re1"}, 32'({re1, addr1, busy1, done1}), 32'd0);
    chk({tag, "_out0"}, {s0.im_data, s0.re_data}, 32'd0);
    chk({tag, "_out1"}, {s1.im_data, s1.re_data}, 32'd0);
    chk({tag, "_flags"}, 32'({s0.data_valid, s0.data_sof, s0.data_eof,
                              s1.data_valid, s1.data_sof, s1.data_eof}), 32'd0);
  endtask

  task automatic start_frame(int lin, logic br);
    int l = (lin < 1) ? 1 : (lin > AW) ? AW : lin;
    exp_n = 1 << l;
    for (int k = 0; k < exp_n; k++) exp_addr[k] = br ? brev(k, l) : k;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    for (int d = 0; d < 2; d++) begin
      ra[d] = 0; wd[d] = 0; first_rd[d] = -1; first_vld[d] = -1;
      sof_c[d] = -1; eof_c[d] = -1; done_c[d] = -1; stall[d] = 1'b0;
    end
    armed = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    flog2 = 5'(lin);
`ifdef FFT_RD_BITREV_EN
    bitrev = br;
`endif
    en = 1'b1; ready = 1'b1; c0 = cyc;
    @(posedge clk); #1;
    en = 1'b0; armed = 1'b1;
    chk("busy_start0", 32'(busy0), 32'd1);
    chk("busy_start1", 32'(busy1), 32'd1);
  endtask

  task automatic run_frame(int lin, logic br, int mode, bit poke, bit timing);
    int n = 0;
    start_frame(lin, br);
    while (!(done_c[0] >= 0 && done_c[1] >= 0) && n < 3000) begin
      ready = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 3 == 0) : 1'($urandom_range(1, 0));
      if (poke && n == 2) begin en = 1'b1; flog2 = 5'd2; end
      else en = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    en = 1'b0; ready = 1'b1;
    chk("timeout", 32'(n < 3000), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reads%0d", d), 32'(ra[d]), 32'(exp_n));
      chk($sformatf("words%0d", d), 32'(wd[d]), 32'(exp_n));
      chk($sformatf("done_after_eof%0d", d), 32'(done_c[d]), 32'(eof_c[d] + 1));
    end
    chk("busy_end", 32'({busy0, busy1}), 32'd0);
    if (timing) begin
      chk("t_first_rd0", 32'(first_rd[0]), 32'(c0 + 1));
      chk("t_first_vld0", 32'(first_vld[0]), 32'(c0 + 3));
      chk("t_sof0", 32'(sof_c[0]), 32'(c0 + 3));
      chk("t_eof0", 32'(eof_c[0]), 32'(c0 + 2 + exp_n));
      chk("t_done0", 32'(done_c[0]), 32'(c0 + 3 + exp_n));
      chk("t_first_rd1", 32'(first_rd[1]), 32'(c0 + 1));
      chk("t_first_vld1", 32'(first_vld[1]), 32'(first_rd[1] + 4));
      chk("t_rate1", 32'(eof_c[1] - sof_c[1]), 32'(exp_n - 1));
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #6 chk_quiet("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    run_frame(3, 1'b0, 0, 1'b0, 1'b1);
    run_frame(3, 1'b0, 1, 1'b0, 1'b0);
`ifdef FFT_RD_BITREV_EN
    run_frame(3, 1'b1, 0, 1'b0, 1'b0);
    run_frame(5, 1'b1, 2, 1'b0, 1'b0);
`endif
    run_frame(0, 1'b0, 0, 1'b1, 1'b0);
    run_frame(20, 1'b0, 2, 1'b1, 1'b0);

    // abort a frame with reset, then a clean frame must follow
    start_frame(5, 1'b0);
    ready = 1'b0;
    repeat (6) @(posedge clk);
    #1 mon_en = 1'b0; armed = 1'b0; rst_n = 1'b0;
    #1 chk_quiet("midreset");
    @(posedge clk); #1 rst_n = 1'b1; ready = 1'b1;
    chk("no_done_after_reset", 32'({done0, done1}), 32'd0);
    run_frame(3, 1'b0, 0, 1'b0, 1'b1);

    run_frame(6, 1'b0, 2, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
